// File: rtl/cache_ram_ctrl.sv
// Write-port controller for the branch-predictor cache RAM: round-robin
// arbitration of two writers onto one registered update port, plus a full-array flush sweep.
module cache_ram_ctrl #(
  parameter int                ADDR_W    = 10,
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] FLUSH_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_req,
  output logic              busy,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              up_en,
  output logic [ADDR_W-1:0] up_addr,
  output logic [DATA_W-1:0] up_data
);

  // Handshake: a write transfers on a rising edge where valid && ready are both
  // high; ready is combinational and only high in RUN; requesters hold addr/data
  // stable while valid is high and ready is low.

  typedef enum logic {ST_FLUSH, ST_RUN} state_t;
  typedef enum logic {PRIO_A, PRIO_B} prio_t;

  state_t             state, state_d;
  prio_t              prio, prio_d;
  logic [ADDR_W-1:0]  cnt, cnt_d;
  logic               up_en_d;
  logic [ADDR_W-1:0]  up_addr_d;
  logic [DATA_W-1:0]  up_data_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_FLUSH;
      prio    <= PRIO_A;
      cnt     <= '0;
      up_en   <= 1'b0;
      up_addr <= '0;
      up_data <= '0;
    end else begin
      state   <= state_d;
      prio    <= prio_d;
      cnt     <= cnt_d;
      up_en   <= up_en_d;
      up_addr <= up_addr_d;
      up_data <= up_data_d;
    end
  end

  always_comb begin
    state_d   = state;
    prio_d    = prio;
    cnt_d     = cnt;
    up_en_d   = 1'b0;
    up_addr_d = up_addr;
    up_data_d = up_data;
    a_ready   = 1'b0;
    b_ready   = 1'b0;
    case (state)
      ST_FLUSH: begin
        // cnt wraps to 0 on the last entry, so RUN always starts with cnt = 0.
        up_en_d   = 1'b1;
        up_addr_d = cnt;
        up_data_d = FLUSH_VAL;
        cnt_d     = cnt + ADDR_W'(1);
        if (cnt == {ADDR_W{1'b1}}) state_d = ST_RUN;
      end
      ST_RUN: begin
        a_ready = a_valid && (!b_valid || prio == PRIO_A);
        b_ready = b_valid && (!a_valid || prio == PRIO_B);
        if (a_ready) begin
          up_en_d   = 1'b1;
          up_addr_d = a_addr;
          up_data_d = a_data;
          prio_d    = PRIO_B;
        end else if (b_ready) begin
          up_en_d   = 1'b1;
          up_addr_d = b_addr;
          up_data_d = b_data;
          prio_d    = PRIO_A;
        end
        // A grant in the same cycle as flush_req is still issued above.
        if (flush_req) begin
          state_d = ST_FLUSH;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_FLUSH;
    endcase
  end

  assign busy = (state == ST_FLUSH);

endmodule

// File: tb/tb_cache_ram_ctrl.sv
// Bench for cache_ram_ctrl: a bench-side arbitration model pushes expected RAM
// writes into a queue, and a monitor pops and compares each up_en cycle.
module tb_cache_ram_ctrl;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int N  = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush_req = 1'b0;
  logic          busy;
  logic          a_valid = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_data = '0;
  logic          a_ready;
  logic          b_valid = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_data = '0;
  logic          b_ready;
  logic          up_en;
  logic [AW-1:0] up_addr;
  logic [DW-1:0] up_data;

  logic [AW+DW-1:0] exp_q[$];
  int               tests_run = 0;
  int               fails = 0;
  logic             m_prio = 1'b0;   // 0 = A has priority
  logic [AW-1:0]    last_addr = '0;
  logic [DW-1:0]    last_data = '0;

  cache_ram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .FLUSH_VAL('0)) dut (
    .clk(clk), .reset(reset), .flush_req(flush_req), .busy(busy),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .up_en(up_en), .up_addr(up_addr), .up_data(up_data)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  // scoreboard monitor
  always @(posedge clk) begin
    logic [AW+DW-1:0] exp_w;
    #1;
    if (up_en) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: got addr=%h data=%h, expected no write", up_addr, up_data);
      end else begin
        exp_w = exp_q.pop_front();
        if ({up_addr, up_data} !== exp_w) begin
          fails++;
          $display("FAIL write: got addr=%h data=%h, expected addr=%h data=%h",
                   up_addr, up_data, exp_w[AW+DW-1:DW], exp_w[DW-1:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic push_flush();
    for (int i = 0; i < N; i++) exp_q.push_back({AW'(i), DW'(0)});
    last_addr = AW'(N - 1);
    last_data = '0;
  endtask

  task automatic idle_inputs();
    a_valid = 1'b0; b_valid = 1'b0; flush_req = 1'b0;
  endtask

  // Called at a negedge; asserts reset, checks reset values, releases at a negedge.
  task automatic apply_reset(input string tag);
    reset = 1'b1;
    idle_inputs();
    #1;
    tests_run++;
    if (up_en !== 1'b0 || up_addr !== '0 || up_data !== '0 || busy !== 1'b1 ||
        a_ready !== 1'b0 || b_ready !== 1'b0) begin
      fails++;
      $display("FAIL %s_values: got en=%b addr=%h data=%h busy=%b ar=%b br=%b, expected 0 0 0 1 0 0",
               tag, up_en, up_addr, up_data, busy, a_ready, b_ready);
    end
    exp_q.delete();
    m_prio = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    push_flush();
  endtask

  // Starts at a negedge with busy expected high; counts busy cycles.
  task automatic wait_flush(input string tag, input int pulse_at, input logic hold_valid);
    int   cycles = 0;
    logic rdy_seen = 1'b0;
    while (busy && cycles < 3000) begin
      cycles++;
      flush_req = (pulse_at >= 0) && up_en && (int'(up_addr) == pulse_at);
      a_valid = hold_valid; a_addr = 10'h055; a_data = 32'h0000_00AA;
      b_valid = hold_valid; b_addr = 10'h0AA; b_data = 32'h0000_00BB;
      #1;
      if (a_ready || b_ready) rdy_seen = 1'b1;
      @(negedge clk);
    end
    idle_inputs();
    tests_run++;
    if (cycles !== N) begin
      fails++;
      $display("FAIL %s_busy_len: got %0d cycles, expected %0d", tag, cycles, N);
    end
    tests_run++;
    if (rdy_seen !== 1'b0) begin
      fails++;
      $display("FAIL %s_ready_in_flush: got ready=1 during flush, expected 0", tag);
    end
    tests_run++;
    if (exp_q.size() !== 0) begin
      fails++;
      $display("FAIL %s_flush_writes: got %0d writes missing, expected 0", tag, exp_q.size());
    end
  endtask

  // One request cycle, called at a negedge; returns at the next negedge.
  task automatic issue(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input logic bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                       input logic fl, input string tag);
    logic ea, eb;
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    flush_req = fl;
    #1;
    ea = av && (!bv || m_prio == 1'b0);
    eb = bv && (!av || m_prio == 1'b1);
    tests_run++;
    if (a_ready !== ea || b_ready !== eb) begin
      fails++;
      $display("FAIL %s_ready: got a_ready=%b b_ready=%b, expected %b %b", tag, a_ready, b_ready, ea, eb);
    end
    if (ea) begin
      exp_q.push_back({aa, ad}); m_prio = 1'b1; last_addr = aa; last_data = ad;
    end else if (eb) begin
      exp_q.push_back({ba, bd}); m_prio = 1'b0; last_addr = ba; last_data = bd;
    end
    @(negedge clk);
    idle_inputs();
    if (fl) push_flush();
  endtask

  task automatic drain(input string tag);
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (exp_q.size() !== 0) begin
      fails++;
      $display("FAIL %s_drain: got %0d writes pending, expected 0", tag, exp_q.size());
    end
  endtask

  // test scenarios
  task automatic test_reset();
    @(negedge clk);
    apply_reset("reset");
    wait_flush("reset", -1, 1'b0);
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < 6; i++)
      issue(1'b1, 10'h010, 32'hAAAA_0010, 1'b1, 10'h020, 32'hBBBB_0020, 1'b0, "rr");
    drain("rr");
  endtask

  task automatic test_single_b();
    for (int i = 1; i <= 4; i++)
      issue(1'b0, 10'h000, 32'h0, 1'b1, 10'h040 + AW'(i), 32'hDEAD_0000 + DW'(i), 1'b0, "only_b");
    drain("only_b");
    tests_run++;
    if (up_en !== 1'b0 || up_addr !== last_addr || up_data !== last_data) begin
      fails++;
      $display("FAIL idle_hold: got en=%b addr=%h data=%h, expected 0 %h %h",
               up_en, up_addr, up_data, last_addr, last_data);
    end
    for (int i = 0; i < 2; i++)
      issue(1'b1, 10'h1A5, 32'hCAFE_0001, 1'b1, 10'h25A, 32'hCAFE_0002, 1'b0, "both_after_b");
    drain("both_after_b");
  endtask

  task automatic test_flush_req_with_grant();
    issue(1'b1, 10'h3FF, 32'h1234_5678, 1'b0, 10'h000, 32'h0, 1'b1, "flush_grant");
    wait_flush("flush_grant", -1, 1'b0);
    issue(1'b1, 10'h123, 32'h0BAD_F00D, 1'b0, 10'h000, 32'h0, 1'b0, "resume_a");
    issue(1'b0, 10'h000, 32'h0, 1'b1, 10'h321, 32'h600D_F00D, 1'b0, "resume_b");
    for (int i = 0; i < 8; i++)
      issue($urandom_range(0, 1), AW'($urandom_range(0, N - 1)), $urandom,
            $urandom_range(0, 1), AW'($urandom_range(0, N - 1)), $urandom, 1'b0, "random");
    drain("resume");
  endtask

  task automatic test_reset_mid_flush();
    int guard = 0;
    issue(1'b0, 10'h000, 32'h0, 1'b0, 10'h000, 32'h0, 1'b1, "pre_mid");
    while (!(up_en && up_addr == 10'd500) && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    tests_run++;
    if (guard >= 3000) begin
      fails++;
      $display("FAIL reach_500: got no write to addr 500, expected one");
    end
    apply_reset("mid_reset");
    wait_flush("mid_reset", -1, 1'b0);
  endtask

  task automatic test_flush_req_ignored();
    issue(1'b0, 10'h000, 32'h0, 1'b0, 10'h000, 32'h0, 1'b1, "pre_ignore");
    wait_flush("ignore", 100, 1'b1);
    issue(1'b1, 10'h0F0, 32'h5555_AAAA, 1'b1, 10'h00F, 32'hAAAA_5555, 1'b0, "post_ignore");
    drain("post_ignore");
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_b();
    test_flush_req_with_grant();
    test_reset_mid_flush();
    test_flush_req_ignored();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
